mem_port_arbiter: RTL

//  Shares one single-ported memory bus between instruction fetch (IF) and the

---
 rtl/mem_port_if.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_if.sv
// Request/response bundle around mem_port_arbiter: fetch port, data port,
// the shared memory bus and the stall outputs.
interface mem_port_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned STRB_W = XLEN / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic              if_err;
    logic [XLEN-1:0]   if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [XLEN-1:0]   dm_wdata;
    logic [STRB_W-1:0] dm_wstrb;
    logic              dm_ready;
    logic              dm_err;
    logic [XLEN-1:0]   dm_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    logic              stall_if;
    logic              stall_mem;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output if_ready, if_err, if_rdata,
        output dm_ready, dm_err, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  if_ready, if_err, if_rdata,
        input  dm_ready, dm_err, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and the data
// stage, one outstanding transaction at a time, with fairness and a watchdog.
module mem_port_arbiter #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned FAIRNESS = 4,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic      clk,
    input  logic      rst_n,
    mem_port_if.slave bus
);
    localparam int unsigned STRB_W   = XLEN / 8;
    localparam int unsigned STREAK_W = $clog2(FAIRNESS + 1);
    localparam int unsigned WDOG_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          WDOG_EN  = (TIMEOUT != 0);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;
    typedef enum logic {OWN_IF, OWN_DM} owner_e;

    state_e              state_q,     state_d;
    owner_e              owner_q,     owner_d;
    logic [STREAK_W-1:0] streak_q,    streak_d;
    logic [WDOG_W-1:0]   wdog_q,      wdog_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;

    logic done_c;
    logic abort_c;
    logic timeout_c;
    logic fetch_wins_c;
    logic own_if_c;
    logic if_ready_c;
    logic dm_ready_c;

    // Watchdog fires once TIMEOUT whole cycles have been spent in REQ/WAIT.
    assign timeout_c    = WDOG_EN && (wdog_q == WDOG_W'(TIMEOUT));
    // Data has priority unless it has starved a pending fetch FAIRNESS times.
    assign fetch_wins_c = bus.if_req && (!bus.dm_req || (streak_q == STREAK_W'(FAIRNESS)));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        wdog_d      = '0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        done_c      = 1'b0;
        abort_c     = 1'b0;

        if (!bus.if_req) begin
            streak_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    state_d   = S_REQ;
                    mem_req_d = 1'b1;
                    if (fetch_wins_c) begin
                        owner_d     = OWN_IF;
                        streak_d    = '0;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = '0;
                        mem_wstrb_d = '0;
                    end else begin
                        owner_d     = OWN_DM;
                        mem_we_d    = bus.dm_we;
                        mem_addr_d  = bus.dm_addr;
                        mem_wdata_d = bus.dm_wdata;
                        mem_wstrb_d = bus.dm_wstrb;
                        if (bus.if_req) begin
                            streak_d = streak_q + STREAK_W'(1);
                        end
                    end
                end
            end
            S_REQ: begin
                wdog_d = wdog_q + WDOG_W'(1);
                if (timeout_c) begin
                    done_c    = 1'b1;
                    abort_c   = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end else if (bus.mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                wdog_d = wdog_q + WDOG_W'(1);
                // A response in the watchdog cycle still counts as a real completion.
                if (bus.mem_rvalid) begin
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                end else if (timeout_c) begin
                    done_c  = 1'b1;
                    abort_c = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_IF;
            streak_q    <= '0;
            wdog_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            wdog_q      <= wdog_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign own_if_c   = (owner_q == OWN_IF);
    assign if_ready_c = done_c & own_if_c;
    assign dm_ready_c = done_c & ~own_if_c;

    assign bus.if_ready  = if_ready_c;
    assign bus.if_err    = abort_c & own_if_c;
    assign bus.if_rdata  = (if_ready_c & ~abort_c) ? bus.mem_rdata : '0;
    // Stores complete with zero read data.
    assign bus.dm_ready  = dm_ready_c;
    assign bus.dm_err    = abort_c & ~own_if_c;
    assign bus.dm_rdata  = (dm_ready_c & ~abort_c & ~mem_we_q) ? bus.mem_rdata : '0;

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;

    assign bus.stall_if  = bus.if_req & ~if_ready_c;
    assign bus.stall_mem = bus.dm_req & ~dm_ready_c;
endmodule
